// File: rtl/fma_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a fixed-latency FMA pipeline.
// Per-requester credits reserve result-FIFO slots at issue time, so writeback never overflows.

module fma_issue_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic        nonempty,
    output logic [31:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][31:0] mem_q;
    logic [PW-1:0]          wptr_q, rptr_q;
    logic [2:0]             cnt_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q] <= wr_data;
                wptr_q        <= inc(wptr_q);
            end
            if (rd_en) rptr_q <= inc(rptr_q);
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign nonempty = (cnt_q != '0);
    assign head     = nonempty ? mem_q[rptr_q] : '0;
endmodule

module fma_issue_arbiter #(
    parameter int LAT   = 3,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [95:0] req0_abc,
    input  logic [95:0] req1_abc,
    output logic        fma_in_valid,
    output logic [31:0] fma_a,
    output logic [31:0] fma_b,
    output logic [31:0] fma_c,
    input  logic [31:0] fma_res,
    output logic        resp0_valid,
    output logic        resp1_valid,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic [31:0] resp0_data,
    output logic [31:0] resp1_data,
    output logic        busy
);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [1:0][2:0]  credit_q, credit_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       elig, grant, pop, fifo_wr, fifo_ne, resp_rdy;
    logic [1:0][31:0] fifo_head;
    logic [95:0]      last_q, issue_abc;
    logic [LAT-1:0]   tag_vld_q, tag_id_q;
    logic             issue;

    assign resp_rdy = {resp1_ready, resp0_ready};

    // Gating with rst keeps the combinational handshake quiet while reset is held.
    always_comb begin
        grant = 2'b00;
        for (int i = 0; i < 2; i++)
            elig[i] = rst & req_valid[i] & (credit_q[i] != 3'd0);
        if (&elig) grant[ptr_q] = 1'b1;
        else       grant = elig;
    end

    assign issue     = |grant;
    assign req_ready = grant;
    assign issue_abc = grant[1] ? req1_abc : (grant[0] ? req0_abc : last_q);
    assign fma_in_valid = issue;
    assign fma_a = issue_abc[95:64];
    assign fma_b = issue_abc[63:32];
    assign fma_c = issue_abc[31:0];
    assign ptr_d = issue ? grant[0] : ptr_q;

    always_comb begin
        credit_d = credit_q;
        for (int i = 0; i < 2; i++) begin
            pop[i]     = fifo_ne[i] & resp_rdy[i];
            fifo_wr[i] = tag_vld_q[LAT-1] & (tag_id_q[LAT-1] == 1'(i));
            case ({grant[i], pop[i]})
                2'b10:   credit_d[i] = credit_q[i] - 3'd1;
                2'b01:   credit_d[i] = credit_q[i] + 3'd1;
                default: credit_d[i] = credit_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q  <= {DEPTH_C, DEPTH_C};
            ptr_q     <= 1'b0;
            last_q    <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            credit_q     <= credit_d;
            ptr_q        <= ptr_d;
            last_q       <= issue_abc;
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= grant[1];
            for (int j = 1; j < LAT; j++) begin
                tag_vld_q[j] <= tag_vld_q[j-1];
                tag_id_q[j]  <= tag_id_q[j-1];
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        fma_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (fifo_wr[i]),
            .wr_data  (fma_res),
            .rd_en    (pop[i]),
            .nonempty (fifo_ne[i]),
            .head     (fifo_head[i])
        );
    end

    assign resp0_valid = fifo_ne[0];
    assign resp1_valid = fifo_ne[1];
    assign resp0_data  = fifo_head[0];
    assign resp1_data  = fifo_head[1];
    assign busy        = (|tag_vld_q) | (|fifo_ne);
endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Randomized bench for fma_issue_arbiter: per-requester expected-result queues fed at issue,
// drained by a monitor on response handshakes; the FMA pipe is emulated with a cycle-indexed table.

module tb_fma_issue_arbiter;
    localparam int LAT   = 3;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  rv  = '0;
    logic [1:0]  rr  = '0;
    logic [95:0] abc0 = '0, abc1 = '0;
    logic [31:0] fma_res = '0;
    logic [1:0]  req_ready;
    logic        fma_in_valid, resp0_valid, resp1_valid, busy;
    logic [31:0] fma_a, fma_b, fma_c, resp0_data, resp1_data;

    fma_issue_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_ready(req_ready),
        .req0_abc(abc0), .req1_abc(abc1), .fma_in_valid(fma_in_valid),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_res(fma_res),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(rr[0]), .resp1_ready(rr[1]),
        .resp0_data(resp0_data), .resp1_data(resp1_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int rdy; logic [31:0] d; } exp_t;
    exp_t        q0[$], q1[$];
    int          outst[2];
    int          ptr_m;
    logic [95:0] last_m;
    int          cyc = 0;
    int          checks = 0, failures = 0;
    logic [31:0] sched [int];

    function automatic logic [31:0] fmodel(input logic [95:0] t);
        if (t == {32'h3F800000, 32'h40000000, 32'h40400000}) return 32'h40A00000;
        return t[95:64] * t[63:32] + t[31:0];
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // FMA pipe emulation: result exactly LAT cycles after issue, junk otherwise.
    always @(posedge clk) begin
        #1;
        fma_res = sched.exists(cyc) ? sched[cyc] : $urandom;
    end

    always @(negedge clk) begin
        int   g, sz;
        logic expv;
        exp_t h;
        logic [1:0] rv_q, rdy_act;
        logic [31:0] dat_act;
        if (fma_in_valid) sched[cyc + LAT] = fmodel({fma_a, fma_b, fma_c});
        if (!rst) begin
            chk("rst_req_ready", 96'(req_ready), 96'd0);
            chk("rst_fma_in_valid", 96'(fma_in_valid), 96'd0);
            chk("rst_fma_abc", {fma_a, fma_b, fma_c}, 96'd0);
            chk("rst_resp_valid", 96'({resp1_valid, resp0_valid}), 96'd0);
            chk("rst_resp_data", 96'({resp1_data, resp0_data}), 96'd0);
            chk("rst_busy", 96'(busy), 96'd0);
            q0.delete(); q1.delete();
            outst[0] = 0; outst[1] = 0; ptr_m = 0; last_m = '0;
        end else begin
            chk("busy", 96'(busy), 96'((outst[0] + outst[1]) > 0));
            rv_q = rv;
            g = -1;
            if (rv_q[0] && outst[0] < DEPTH && rv_q[1] && outst[1] < DEPTH) g = ptr_m;
            else if (rv_q[0] && outst[0] < DEPTH) g = 0;
            else if (rv_q[1] && outst[1] < DEPTH) g = 1;
            chk("req_ready", 96'(req_ready), (g < 0) ? 96'd0 : 96'(2'b01 << g));
            chk("fma_in_valid", 96'(fma_in_valid), 96'(g >= 0));
            if (g >= 0) last_m = (g == 1) ? abc1 : abc0;
            chk("fma_abc", {fma_a, fma_b, fma_c}, last_m);
            rdy_act = {resp1_valid, resp0_valid};
            for (int i = 0; i < 2; i++) begin
                sz = (i == 1) ? q1.size() : q0.size();
                expv = 1'b0;
                if (sz > 0) begin
                    h = (i == 1) ? q1[0] : q0[0];
                    expv = (h.rdy <= cyc);
                end
                chk($sformatf("resp%0d_valid", i), 96'(rdy_act[i]), 96'(expv));
                if (expv) begin
                    dat_act = (i == 1) ? resp1_data : resp0_data;
                    chk($sformatf("resp%0d_data", i), 96'(dat_act), 96'(h.d));
                    if (rr[i]) begin
                        if (i == 1) void'(q1.pop_front()); else void'(q0.pop_front());
                        outst[i]--;
                    end
                end
            end
            if (g >= 0) begin
                h.rdy = cyc + LAT + 1;
                h.d   = fmodel(last_m);
                if (g == 1) q1.push_back(h); else q0.push_back(h);
                outst[g]++;
                ptr_m = 1 - g;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b0; step(); rst = 1'b1;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b1;
        rr  = 2'b11;
        // single op with the known 1*2+3 operands
        abc0 = {32'h3F800000, 32'h40000000, 32'h40400000};
        rv = 2'b01; step(); rv = 2'b00;
        repeat (LAT + 4) step();
        // contention from a fresh reset: alternation starts at requester 0
        pulse_reset();
        rv = 2'b11;
        for (int k = 0; k < 4; k++) begin
            abc0 = {$urandom, $urandom, $urandom}; abc1 = {$urandom, $urandom, $urandom};
            step();
        end
        rv = 2'b00; repeat (8) step();
        // backpressure on requester 0, then a single pop
        rr = 2'b10; rv = 2'b01;
        repeat (8) step();
        rr = 2'b11; step(); rr = 2'b10;
        repeat (6) step();
        // isolation: requester 0 exhausted, requester 1 keeps flowing
        rv = 2'b11;
        for (int k = 0; k < 10; k++) begin
            abc1 = {$urandom, $urandom, $urandom};
            step();
        end
        rv = 2'b00; rr = 2'b11; repeat (10) step();
        // reset mid-flight
        rv = 2'b11; step(); step();
        rst = 1'b0; rv = 2'b00; step(); rst = 1'b1;
        repeat (LAT + 6) step();
        // random traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            rv   = 2'($urandom_range(0, 3));
            rr   = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6)};
            abc0 = {$urandom, $urandom, $urandom};
            abc1 = {$urandom, $urandom, $urandom};
            rst  = ($urandom_range(0, 299) != 0);
            step();
        end
        rst = 1'b1; rv = 2'b00; rr = 2'b11;
        repeat (12) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
